// File: rtl/cabina_ascensor_if.sv
// Car command/status bundle between the dispatcher and one elevator car.
// The dispatcher drives the destination and reads back the status.
interface cabina_ascensor_if;
  logic [2:0] destino_asc;
  logic [1:0] piso_asc;
  logic [1:0] direccion_asc;
  logic       ocupado_asc;
  logic       puerta_abierta;

  modport master (
    output destino_asc,
    input  piso_asc,
    input  direccion_asc,
    input  ocupado_asc,
    input  puerta_abierta
  );

  modport slave (
    input  destino_asc,
    output piso_asc,
    output direccion_asc,
    output ocupado_asc,
    output puerta_abierta
  );
endinterface

// File: rtl/cabina_ascensor.sv
// Per-car motion and door controller: one floor per TICKS_PISO cycles,
// door open for TICKS_PUERTA cycles, one pending request slot.
module cabina_ascensor #(
  parameter int TICKS_PISO   = 50_000_000,
  parameter int TICKS_PUERTA = 100_000_000
) (
  input  logic               clk,
  input  logic               rst,
  cabina_ascensor_if.slave   bus
);

  localparam int TMAX = (TICKS_PISO > TICKS_PUERTA) ?
                        TICKS_PISO : TICKS_PUERTA;
  localparam int CW = $clog2(TMAX);
  localparam logic [CW-1:0] FIN_PISO   = CW'(TICKS_PISO - 1);
  localparam logic [CW-1:0] FIN_PUERTA = CW'(TICKS_PUERTA - 1);

  typedef enum logic [1:0] {
    REPOSO = 2'd0,
    MOVER  = 2'd1,
    PUERTA = 2'd2
  } estado_t;

  estado_t       estado, estado_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    piso, piso_n;
  logic [1:0]    objetivo, objetivo_n;
  logic [1:0]    dir, dir_n;
  logic [2:0]    dest_prev;
  logic          pend_v;
  logic [1:0]    pend;

  logic       nuevo;
  logic       lanzar;
  logic [1:0] target;
  logic [1:0] piso_sig;
  logic       fin_piso;
  logic       fin_puerta;

  // The upstream register holds its value, so only a change is a request.
  assign nuevo = (bus.destino_asc != dest_prev) &&
                 !bus.destino_asc[2];
  assign lanzar     = nuevo || pend_v;
  assign target     = nuevo ? bus.destino_asc[1:0] : pend;
  assign piso_sig   = (dir == 2'b01) ? piso + 2'd1 : piso - 2'd1;
  assign fin_piso   = (cnt == FIN_PISO);
  assign fin_puerta = (cnt == FIN_PUERTA);

  always_ff @(posedge clk) begin
    if (rst) begin
      estado    <= REPOSO;
      cnt       <= '0;
      piso      <= 2'd0;
      objetivo  <= 2'd0;
      dir       <= 2'b00;
      dest_prev <= 3'b100;
      pend_v    <= 1'b0;
      pend      <= 2'd0;
    end else begin
      estado    <= estado_n;
      cnt       <= cnt_n;
      piso      <= piso_n;
      objetivo  <= objetivo_n;
      dir       <= dir_n;
      dest_prev <= bus.destino_asc;
      if (estado == REPOSO) begin
        pend_v <= 1'b0;
      end else if (nuevo) begin
        pend_v <= 1'b1;
        pend   <= bus.destino_asc[1:0];
      end
    end
  end

  always_comb begin
    estado_n   = estado;
    cnt_n      = cnt + CW'(1);
    piso_n     = piso;
    objetivo_n = objetivo;
    dir_n      = dir;
    unique case (estado)
      REPOSO: begin
        cnt_n = '0;
        dir_n = 2'b00;
        if (lanzar) begin
          if (target == piso) begin
            estado_n = PUERTA;
          end else begin
            estado_n   = MOVER;
            objetivo_n = target;
            dir_n      = (target > piso) ? 2'b01 : 2'b10;
          end
        end
      end
      MOVER: begin
        if (fin_piso) begin
          cnt_n  = '0;
          piso_n = piso_sig;
          if (piso_sig == objetivo) begin
            estado_n = PUERTA;
            dir_n    = 2'b00;
          end
        end
      end
      PUERTA: begin
        dir_n = 2'b00;
        if (fin_puerta) begin
          estado_n = REPOSO;
          cnt_n    = '0;
        end
      end
      default: begin
        estado_n = REPOSO;
        cnt_n    = '0;
        dir_n    = 2'b00;
      end
    endcase
  end

  always_comb begin
    bus.piso_asc       = piso;
    bus.direccion_asc  = (estado == MOVER) ? dir : 2'b00;
    bus.ocupado_asc    = (estado != REPOSO);
    bus.puerta_abierta = (estado == PUERTA);
  end

endmodule

// File: tb/tb_cabina_ascensor.sv
// Bench for cabina_ascensor: expected per-cycle status is queued when a
// destination is driven and popped against the car on each falling edge.
module tb_cabina_ascensor;

  localparam int TP = 4;
  localparam int TD = 3;

  typedef struct packed {
    logic [1:0] piso;
    logic [1:0] dir;
    logic       ocup;
    logic       puerta;
  } snap_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  cabina_ascensor_if bus();

  cabina_ascensor #(
    .TICKS_PISO(TP),
    .TICKS_PUERTA(TD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  snap_t exp_q[$];
  int n_eval = 0;
  int n_fail = 0;

  function automatic snap_t observe();
    return '{bus.piso_asc, bus.direccion_asc,
             bus.ocupado_asc, bus.puerta_abierta};
  endfunction

  function automatic void push_idle(int p, int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back('{2'(p), 2'b00, 1'b0, 1'b0});
  endfunction

  function automatic void push_trip(int a, int b);
    logic [1:0] d;
    int n;
    int f;
    d = (b > a) ? 2'b01 : 2'b10;
    n = (b > a) ? b - a : a - b;
    for (int s = 0; s < n; s++) begin
      f = (b > a) ? a + s : a - s;
      for (int c = 0; c < TP; c++)
        exp_q.push_back('{2'(f), d, 1'b1, 1'b0});
    end
    for (int c = 0; c < TD; c++)
      exp_q.push_back('{2'(b), 2'b00, 1'b1, 1'b1});
  endfunction

  task automatic test_reset();
    snap_t e, g;
    int k;
    rst = 1'b1;
    bus.destino_asc = 3'b100;
    push_idle(0, 12);
    k = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      g = observe();
      n_eval++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL reset k=%0d got %b want %b", k, g, e);
      end
      k++;
      if (k == 2) rst = 1'b0;
    end
  endtask

  task automatic test_up_trip();
    snap_t e, g;
    int k;
    bus.destino_asc = 3'b011;
    push_trip(0, 3);
    push_idle(3, 5);
    k = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      g = observe();
      n_eval++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL up_trip k=%0d got %b want %b", k, g, e);
      end
      k++;
    end
  endtask

  task automatic test_down_trip();
    snap_t e, g;
    int k;
    bus.destino_asc = 3'b000;
    push_trip(3, 0);
    push_idle(0, 2);
    k = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      g = observe();
      n_eval++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL down_trip k=%0d got %b want %b", k, g, e);
      end
      k++;
    end
  endtask

  task automatic test_same_floor();
    snap_t e, g;
    int k;
    bus.destino_asc = 3'b010;
    push_trip(0, 2);
    push_idle(2, 2);
    push_idle(2, 2);
    push_trip(2, 2);
    push_idle(2, 2);
    k = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      g = observe();
      n_eval++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL same_floor k=%0d got %b want %b", k, g, e);
      end
      k++;
      if (k == 13) bus.destino_asc = 3'b100;
      if (k == 15) bus.destino_asc = 3'b010;
    end
  endtask

  task automatic test_pending_mid_move();
    snap_t e, g;
    int k;
    bus.destino_asc = 3'b000;
    push_trip(2, 0);
    push_idle(0, 1);
    push_trip(0, 3);
    push_idle(3, 1);
    push_trip(3, 1);
    push_idle(1, 3);
    k = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      g = observe();
      n_eval++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL pending k=%0d got %b want %b", k, g, e);
      end
      k++;
      if (k == 12) bus.destino_asc = 3'b011;
      if (k == 18) bus.destino_asc = 3'b001;
    end
  endtask

  task automatic test_nuevo_wins();
    snap_t e, g;
    int k;
    bus.destino_asc = 3'b011;
    push_trip(1, 3);
    push_idle(3, 1);
    push_trip(3, 2);
    push_idle(2, 4);
    k = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      g = observe();
      n_eval++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL nuevo_wins k=%0d got %b want %b", k, g, e);
      end
      k++;
      if (k == 3)  bus.destino_asc = 3'b000;
      if (k == 12) bus.destino_asc = 3'b010;
    end
  endtask

  task automatic test_reset_mid_move();
    snap_t e, g;
    int k;
    bus.destino_asc = 3'b000;
    push_trip(2, 0);
    push_idle(0, 1);
    push_trip(0, 3);
    k = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      g = observe();
      n_eval++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL reset_mid k=%0d got %b want %b", k, g, e);
      end
      k++;
      if (k == 12) bus.destino_asc = 3'b011;
      if (k == 14) bus.destino_asc = 3'b001;
      if (k == 18) begin
        rst = 1'b1;
        bus.destino_asc = 3'b100;
        exp_q.delete();
        push_idle(0, 10);
      end
      if (k == 20) rst = 1'b0;
    end
  endtask

  initial begin
    bus.destino_asc = 3'b100;
    test_reset();
    test_up_trip();
    test_down_trip();
    test_same_floor();
    test_pending_mid_move();
    test_nuevo_wins();
    test_reset_mid_move();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_eval, n_fail);
    $finish;
  end

endmodule
